// File: rtl/pipelined_adder_if.sv
// Stream bundle for pipelined_adder: operand beat in, result beat out, checker flags.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             fault_inj;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             err;
  logic             err_sticky;

  modport master (
    output in_valid, a, b, cin, sub, fault_inj, out_ready,
    input  in_ready, out_valid, s, cout, ovf, err, err_sticky
  );

  modport slave (
    input  in_valid, a, b, cin, sub, fault_inj, out_ready,
    output in_ready, out_valid, s, cout, ovf, err, err_sticky
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/sub, one CHUNK-bit slice per stage, back-pressurable stream.
// Optional duplicate-and-compare checker enabled by defining ADDER_DMR_EN.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);
  localparam int NSTAGE = WIDTH / CHUNK;

  logic             vld_p [1:NSTAGE];
  logic [WIDTH-1:0] a_p   [1:NSTAGE];
  logic [WIDTH-1:0] bx_p  [1:NSTAGE];
  logic [WIDTH-1:0] res_p [1:NSTAGE];
  logic             cy_p  [1:NSTAGE];
  logic             ovf_p;

  logic             src_vld [0:NSTAGE-1];
  logic [WIDTH-1:0] src_a   [0:NSTAGE-1];
  logic [WIDTH-1:0] src_bx  [0:NSTAGE-1];
  logic [WIDTH-1:0] src_res [0:NSTAGE-1];
  logic             src_cy  [0:NSTAGE-1];
  logic [WIDTH-1:0] nxt_res [1:NSTAGE];
  logic             nxt_cy  [1:NSTAGE];
  logic [CHUNK:0]   psum;
  logic             adv;

  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  function automatic logic ovf_of(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Source of stage k is stage k-1; stage 0 is the operand port itself.
  always_comb begin
    psum       = '0;
    src_vld[0] = bus.in_valid;
    src_a[0]   = bus.a;
    src_bx[0]  = bus.sub ? ~bus.b : bus.b;
    src_cy[0]  = bus.cin ^ bus.sub;
    src_res[0] = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      src_vld[k] = vld_p[k];
      src_a[k]   = a_p[k];
      src_bx[k]  = bx_p[k];
      src_res[k] = res_p[k];
      src_cy[k]  = cy_p[k];
    end
    for (int k = 1; k <= NSTAGE; k++) begin
      psum       = slice_add(src_a[k-1][(k-1)*CHUNK +: CHUNK],
                             src_bx[k-1][(k-1)*CHUNK +: CHUNK], src_cy[k-1]);
      nxt_res[k] = src_res[k-1];
      nxt_res[k][(k-1)*CHUNK +: CHUNK] = psum[CHUNK-1:0];
      nxt_cy[k]  = psum[CHUNK];
    end
`ifdef ADDER_DMR_EN
    // Corrupt only the stored bit; the slice carry stays clean.
    nxt_res[1][0] = nxt_res[1][0] ^ bus.fault_inj;
`endif
  end

  assign adv          = !(vld_p[NSTAGE] && !bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_p[NSTAGE];
  assign bus.s        = res_p[NSTAGE];
  assign bus.cout     = cy_p[NSTAGE];
  assign bus.ovf      = ovf_p;

  // Stages 1..NSTAGE; the last stage doubles as the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTAGE; k++) vld_p[k] <= 1'b0;
      res_p[NSTAGE] <= '0;
      cy_p[NSTAGE]  <= 1'b0;
      ovf_p         <= 1'b0;
    end else if (adv) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        vld_p[k] <= src_vld[k-1];
        a_p[k]   <= src_a[k-1];
        bx_p[k]  <= src_bx[k-1];
        res_p[k] <= nxt_res[k];
        cy_p[k]  <= nxt_cy[k];
      end
      ovf_p <= ovf_of(src_a[NSTAGE-1][WIDTH-1], src_bx[NSTAGE-1][WIDTH-1],
                      nxt_res[NSTAGE][WIDTH-1]);
    end
  end

`ifdef ADDER_DMR_EN
  logic [WIDTH:0] shd_p [1:NSTAGE];
  logic [WIDTH:0] shd_in;
  logic           err_now;
  logic           sticky;

  assign shd_in  = {1'b0, bus.a} + {1'b0, src_bx[0]} + {{WIDTH{1'b0}}, src_cy[0]};
  assign err_now = vld_p[NSTAGE] && ({cy_p[NSTAGE], res_p[NSTAGE]} != shd_p[NSTAGE]);
  assign bus.err        = err_now;
  assign bus.err_sticky = sticky | err_now;

  // Shadow sum travels in lockstep with the primary stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_p[NSTAGE] <= '0;
      sticky        <= 1'b0;
    end else begin
      if (adv) begin
        shd_p[1] <= shd_in;
        for (int k = 2; k <= NSTAGE; k++) shd_p[k] <= shd_p[k-1];
      end
      if (err_now) sticky <= 1'b1;
    end
  end
`else
  logic unused_fault;
  assign unused_fault   = bus.fault_inj;
  assign bus.err        = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table, hand-written stream/stall/reset
// sequences and randomized traffic against a plain-arithmetic reference model.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NSTAGE = WIDTH / CHUNK;
`ifdef ADDER_DMR_EN
  localparam bit DMR = 1'b1;
`else
  localparam bit DMR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();
  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        err;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  res_t exp_q[$];
  int   pop_cyc[$];
  bit   mon_en  = 1'b0;
  bit   rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: integer arithmetic on the operands, not on slices or carries.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic fi);
    res_t        r;
    int          sa, sb, sr;
    logic [16:0] f;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      f      = {1'b0, a} + {1'b0, b} + 17'(cin);
      r.s    = f[15:0];
      r.cout = f[16];
      sr     = sa + sb + int'(cin);
    end else begin
      r.s    = a - b - 16'(cin);
      r.cout = ({1'b0, a} >= ({1'b0, b} + 17'(cin)));
      sr     = sa - sb - int'(cin);
    end
    r.ovf = (sr > 32767) || (sr < -32768);
    r.err = DMR && fi;
    if (r.err) r.s[0] = ~r.s[0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.fault_inj));
  end

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=s:%0h required=no beat", bus.s);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("stream_s", bus.s, e.s);
        chk("stream_cout", bus.cout, e.cout);
        chk("stream_ovf", bus.ovf, e.ovf);
        chk("stream_err", bus.err, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic fi);
    bit acc;
    int g;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.fault_inj = fi;
    bus.in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      g++;
    end while (!acc && g < 200);
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.fault_inj = 1'b0;
    step();
  endtask

  task automatic drain(input string nm);
    int g;
    bus.in_valid = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      step();
      g++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    int   lat, p0;
    logic [15:0] ra, rb;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[9] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.fault_inj = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_sticky", bus.err_sticky, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    step();

    // Directed vectors, one at a time, with latency measurement.
    for (int i = 0; i < 10; i++) begin
      bus.a = tbl[i].a; bus.b = tbl[i].b; bus.cin = tbl[i].cin; bus.sub = tbl[i].sub;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", bus.in_ready, 1);
      chk("vec_idle_out", bus.out_valid, 0);
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      forever begin
        @(negedge clk);
        if (bus.out_valid || lat > 20) break;
        step();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, NSTAGE);
      chk($sformatf("vec%0d_s", i), bus.s, tbl[i].s);
      chk($sformatf("vec%0d_cout", i), bus.cout, tbl[i].cout);
      chk($sformatf("vec%0d_ovf", i), bus.ovf, tbl[i].ovf);
      chk($sformatf("vec%0d_err", i), bus.err, 0);
      step();
    end

    // Streaming: six back-to-back beats must leave back-to-back.
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    p0 = pop_cyc.size();
    for (int i = 1; i <= 6; i++) send(16'(i), 16'(i * 256), 1'b0, 1'b0, 1'b0);
    drain("stream_drain");
    chk("stream_count", pop_cyc.size() - p0, 6);
    if (pop_cyc.size() - p0 == 6) chk("stream_gapless", pop_cyc[p0+5] - pop_cyc[p0], 5);

    // Back-pressure: fill, stall three cycles with a beat waiting, release.
    p0 = pop_cyc.size();
    for (int i = 0; i < 4; i++) send(16'h1000 + 16'(i), 16'h0011, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.a = 16'h2000; bus.b = 16'h0022; bus.cin = 1'b0; bus.sub = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_hold_s", bus.s, (exp_q.size() != 0) ? exp_q[0].s : 16'hxxxx);
      step();
    end
    bus.out_ready = 1'b1;
    send(16'h2000, 16'h0022, 1'b0, 1'b1, 1'b0);
    send(16'h2001, 16'h0033, 1'b1, 1'b0, 1'b0);
    send(16'h2002, 16'h0044, 1'b1, 1'b1, 1'b0);
    drain("bp_drain");
    chk("bp_count", pop_cyc.size() - p0, 7);
    if (pop_cyc.size() - p0 == 7) chk("bp_one_per_cycle", pop_cyc[p0+6] - pop_cyc[p0], 6);

    // Checker: injected fault on one beat, clean beat right after.
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1);
    bus.fault_inj = 1'b0;
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
    idle();
    drain("dmr_drain");
    @(negedge clk);
    chk("dmr_err_idle", bus.err, 0);
    chk("dmr_sticky", bus.err_sticky, DMR);
    step();

    // Randomized traffic with random back-pressure and corner operands.
    rand_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    drain("rand_drain");

    // Reset with three beats in flight: nothing stale may emerge afterwards.
    for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i), 16'h0001, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_s", bus.s, 0);
    chk("mid_rst_cout", bus.cout, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_err_sticky", bus.err_sticky, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    repeat (8) idle();
    send(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0);
    idle();
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
